// File: rtl/instruction_fetch_sequencer.sv
// rtl/instruction_fetch_sequencer.sv - fetch PC sequencer with prefetch FIFO, redirect flush and fault detection
module instruction_fetch_sequencer #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MEMORY_DEPTH = 32,
  parameter int                    FIFO_DEPTH   = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_PC     = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable_i,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  output logic [DATA_WIDTH-1:0] mem_address_o,
  input  logic [DATA_WIDTH-1:0] mem_instruction_i,
  output logic                  instr_valid_o,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0] instr_pc_o,
  input  logic                  instr_ready_i,
  output logic                  fault_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [DATA_WIDTH-1:0] MEM_WORDS = DATA_WIDTH'(MEMORY_DEPTH);
  localparam logic [CW-1:0]         FULL_CNT  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] word_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] word_d [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] wpc_q  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] wpc_d  [FIFO_DEPTH];

  logic pc_legal, redirect_legal, pop, push;

  assign pc_legal       = ({2'b00, pc_q[DATA_WIDTH-1:2]} < MEM_WORDS);
  assign redirect_legal = (redirect_pc_i[1:0] == 2'b00) &&
                          ({2'b00, redirect_pc_i[DATA_WIDTH-1:2]} < MEM_WORDS);

  assign instr_valid_o = (count_q != '0);
  assign pop           = instr_valid_o && instr_ready_i;
  assign push          = (state_q == RUN) && enable_i && !redirect_i && pc_legal &&
                         ((count_q < FULL_CNT) || pop);

  assign mem_address_o = pc_q;
  assign instr_o       = instr_valid_o ? word_q[rd_ptr_q] : '0;
  assign instr_pc_o    = instr_valid_o ? wpc_q[rd_ptr_q]  : '0;
  assign fault_o       = (state_q == FAULT);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    word_d   = word_q;
    wpc_d    = wpc_q;

    if (redirect_i) begin
      // Redirect overrides any fault detection and discards this cycle's pop/push.
      state_d  = !redirect_legal ? FAULT : (enable_i ? RUN : IDLE);
      pc_d     = redirect_pc_i;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      case (state_q)
        IDLE:    if (enable_i) state_d = RUN;
        RUN:     if (!enable_i) state_d = IDLE;
                 else if (!pc_legal) state_d = FAULT;
        default: state_d = state_q;
      endcase

      if (push) begin
        word_d[wr_ptr_q] = mem_instruction_i;
        wpc_d[wr_ptr_q]  = pc_q;
        wr_ptr_d         = wr_ptr_q + 1'b1;
        pc_d             = pc_q + DATA_WIDTH'(4);
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + (push ? CW'(1) : CW'(0)) - (pop ? CW'(1) : CW'(0));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        word_q[i] <= '0;
        wpc_q[i]  <= '0;
      end
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      word_q   <= word_d;
      wpc_q    <= wpc_d;
    end
  end

endmodule
